// File: rtl/rdg_pkg.sv
// Shared types and helpers for the random digit generator.
package rdg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } rdg_state_t;

  // Maximal-length Galois mask for an 8-bit register.
  localparam logic [7:0] RDG_DEFAULT_POLY = 8'hB8;

  function automatic int rdgIdxWidth(input int numDigits);
    return (numDigits <= 1) ? 1 : $clog2(numDigits);
  endfunction

endpackage

// File: rtl/random_digit_gen_lfsr.sv
// Galois LFSR with synchronous load and a guard that never lets the register hold zero.
module lfsr_galois
  import rdg_pkg::*;
#(
  parameter int                LFSR_W = 8,
  parameter logic [LFSR_W-1:0] POLY   = LFSR_W'(RDG_DEFAULT_POLY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] r_q;
  logic [LFSR_W-1:0] w_stepVal;
  logic [LFSR_W-1:0] w_loadVal;

  always_comb begin
    w_stepVal = (r_q >> 1) ^ (r_q[0] ? POLY : '0);
  end

  // An all-zero seed would lock the register up, so it is replaced by 1.
  always_comb begin
    w_loadVal = (load_val == '0) ? LFSR_W'(1) : load_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= LFSR_W'(1);
    end else if (load) begin
      r_q <= w_loadVal;
    end else if (step) begin
      r_q <= w_stepVal;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/random_digit_gen.sv
// Fills a bank of NUM_DIGITS pseudo-random digits, one candidate per clock,
// optionally rejecting repeats within a run.
module random_digit_gen
  import rdg_pkg::*;
#(
  parameter int                NUM_DIGITS = 5,
  parameter int                DIGIT_W    = 3,
  parameter int                LFSR_W     = 8,
  parameter logic [LFSR_W-1:0] POLY       = LFSR_W'(RDG_DEFAULT_POLY),
  parameter bit                UNIQUE     = 1'b0,
  localparam int               IDX_W      = rdgIdxWidth(NUM_DIGITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          use_seed_i,
  input  logic [LFSR_W-1:0]             seed_i,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits_o,
  output logic                          wr_valid_o,
  output logic [IDX_W-1:0]              wr_addr_o,
  output logic [DIGIT_W-1:0]            wr_data_o,
  output logic                          busy_o,
  output logic                          done_o
);

  generate
    if (NUM_DIGITS < 1) begin : g_errNumDigits
      $error("random_digit_gen: NUM_DIGITS must be at least 1");
    end
    if (LFSR_W < DIGIT_W) begin : g_errLfsrWidth
      $error("random_digit_gen: LFSR_W must be at least DIGIT_W");
    end
    if (UNIQUE && (NUM_DIGITS > (1 << DIGIT_W))) begin : g_errUnique
      $error("random_digit_gen: UNIQUE needs NUM_DIGITS <= 2**DIGIT_W");
    end
  endgenerate

  rdg_state_t r_state;
  rdg_state_t w_nextState;

  logic [LFSR_W-1:0]             r_entropy;
  logic [IDX_W-1:0]              r_idx;
  logic [NUM_DIGITS*DIGIT_W-1:0] r_digits;
  logic                          r_wrValid;
  logic [IDX_W-1:0]              r_wrAddr;
  logic [DIGIT_W-1:0]            r_wrData;
  logic                          r_busy;
  logic                          r_done;

  logic [LFSR_W-1:0]  w_lfsrQ;
  logic [LFSR_W-1:0]  w_seed;
  logic [DIGIT_W-1:0] w_cand;
  logic               w_startAcc;
  logic               w_lfsrLoad;
  logic               w_lfsrStep;
  logic               w_dup;
  logic               w_accept;
  logic               w_last;

  lfsr_galois #(
    .LFSR_W (LFSR_W),
    .POLY   (POLY)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (w_lfsrLoad),
    .load_val (w_seed),
    .step     (w_lfsrStep),
    .q        (w_lfsrQ)
  );

  assign w_cand = w_lfsrQ[DIGIT_W-1:0];

  generate
    if (LFSR_W > DIGIT_W) begin : g_lfsrHi
      logic w_unusedLfsrHi;
      assign w_unusedLfsrHi = ^w_lfsrQ[LFSR_W-1:DIGIT_W];
    end
  endgenerate

  // Free-running seed source; it keeps counting through GEN as well.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entropy <= '0;
    end else begin
      r_entropy <= r_entropy + LFSR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (start_i) w_nextState = GEN;
      GEN:     if (w_accept && w_last) w_nextState = DONE;
      DONE:    if (start_i) w_nextState = GEN;
      default: w_nextState = IDLE;
    endcase
  end

  // Only digits already written in this run take part in the repeat check.
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i < int'(r_idx)) && (r_digits[i*DIGIT_W +: DIGIT_W] == w_cand)) begin
        w_dup = 1'b1;
      end
    end
  end

  always_comb begin
    w_startAcc = start_i && ((r_state == IDLE) || (r_state == DONE));
    w_lfsrLoad = w_startAcc;
    w_lfsrStep = (r_state == GEN);
    w_seed     = use_seed_i ? seed_i : r_entropy;
    w_accept   = (r_state == GEN) && !(UNIQUE && w_dup);
    w_last     = (r_idx == IDX_W'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_digits  <= '0;
      r_wrValid <= 1'b0;
      r_wrAddr  <= '0;
      r_wrData  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_wrValid <= w_accept;
      r_busy    <= (w_nextState == GEN);
      r_done    <= (w_nextState == DONE);
      if (w_startAcc) begin
        r_idx <= '0;
      end else if (w_accept) begin
        r_digits[int'(r_idx)*DIGIT_W +: DIGIT_W] <= w_cand;
        r_wrAddr <= r_idx;
        r_wrData <= w_cand;
        if (!w_last) begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  assign digits_o   = r_digits;
  assign wr_valid_o = r_wrValid;
  assign wr_addr_o  = r_wrAddr;
  assign wr_data_o  = r_wrData;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule

// File: tb/tb_random_digit_gen.sv
// Drives three generator configurations with shared stimulus and checks them
// cycle by cycle against a reference built from the digit-generation rules.
module tb_random_digit_gen;

  localparam int NDUT = 3;
  localparam int MAXC = 600;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic       use_seed_i = 1'b1;
  logic [7:0] seed_i = 8'h00;

  logic [14:0] digitsA;
  logic        validA, busyA, doneA;
  logic [2:0]  addrA, dataA;
  logic [20:0] digitsB;
  logic        validB, busyB, doneB;
  logic [2:0]  addrB, dataB;
  logic [20:0] digitsC;
  logic        validC, busyC, doneC;
  logic [2:0]  addrC, dataC;

  int checkCount = 0;
  int errorCount = 0;
  logic [7:0] entropyModel;

  bit         expValid [NDUT][MAXC+1];
  logic [2:0] expData  [NDUT][MAXC+1];
  logic [2:0] expAddr  [NDUT][MAXC+1];
  int         doneCyc  [NDUT];
  logic [63:0] expDigits [NDUT];

  random_digit_gen #(.NUM_DIGITS(5), .UNIQUE(1'b0)) dutA (
    .clk(clk), .rst(rst), .start_i(start_i), .use_seed_i(use_seed_i), .seed_i(seed_i),
    .digits_o(digitsA), .wr_valid_o(validA), .wr_addr_o(addrA), .wr_data_o(dataA),
    .busy_o(busyA), .done_o(doneA));

  random_digit_gen #(.NUM_DIGITS(7), .UNIQUE(1'b0)) dutB (
    .clk(clk), .rst(rst), .start_i(start_i), .use_seed_i(use_seed_i), .seed_i(seed_i),
    .digits_o(digitsB), .wr_valid_o(validB), .wr_addr_o(addrB), .wr_data_o(dataB),
    .busy_o(busyB), .done_o(doneB));

  random_digit_gen #(.NUM_DIGITS(7), .UNIQUE(1'b1)) dutC (
    .clk(clk), .rst(rst), .start_i(start_i), .use_seed_i(use_seed_i), .seed_i(seed_i),
    .digits_o(digitsC), .wr_valid_o(validC), .wr_addr_o(addrC), .wr_data_o(dataC),
    .busy_o(busyC), .done_o(doneC));

  always #5 clk = ~clk;

  // Entropy seen by the design: clock edges since reset, modulo 256.
  always @(posedge clk or posedge rst) begin
    if (rst) entropyModel <= 8'd0;
    else     entropyModel <= entropyModel + 8'd1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic fetchDut(input int d, output logic [63:0] dig, output logic v,
                          output logic [2:0] a, output logic [2:0] dt,
                          output logic b, output logic dn);
    case (d)
      0:       begin dig = 64'(digitsA); v = validA; a = addrA; dt = dataA; b = busyA; dn = doneA; end
      1:       begin dig = 64'(digitsB); v = validB; a = addrB; dt = dataB; b = busyB; dn = doneB; end
      default: begin dig = 64'(digitsC); v = validC; a = addrC; dt = dataC; b = busyC; dn = doneC; end
    endcase
  endtask

  task automatic checkIdle(input string tag);
    logic [63:0] dig;
    logic v, b, dn;
    logic [2:0] a, dt;
    for (int d = 0; d < NDUT; d++) begin
      fetchDut(d, dig, v, a, dt, b, dn);
      checkOutput($sformatf("%s d%0d digits", tag, d), dig, 64'd0);
      checkOutput($sformatf("%s d%0d valid", tag, d), 64'(v), 64'd0);
      checkOutput($sformatf("%s d%0d addr", tag, d), 64'(a), 64'd0);
      checkOutput($sformatf("%s d%0d data", tag, d), 64'(dt), 64'd0);
      checkOutput($sformatf("%s d%0d busy", tag, d), 64'(b), 64'd0);
      checkOutput($sformatf("%s d%0d done", tag, d), 64'(dn), 64'd0);
    end
  endtask

  // Reference: walk the LFSR sequence and record which cycle writes which digit.
  task automatic buildModel(input int d, input logic [7:0] s);
    int n;
    bit uniq;
    bit seen [8];
    logic [7:0] l;
    logic [2:0] c;
    int accepted;
    n = (d == 0) ? 5 : 7;
    uniq = (d == 2);
    l = (s == 8'd0) ? 8'd1 : s;
    accepted = 0;
    doneCyc[d] = MAXC;
    expDigits[d] = '0;
    for (int i = 0; i < 8; i++) seen[i] = 1'b0;
    for (int k = 0; k <= MAXC; k++) begin
      expValid[d][k] = 1'b0;
      expData[d][k] = '0;
      expAddr[d][k] = '0;
    end
    for (int k = 1; (k <= MAXC) && (accepted < n); k++) begin
      c = l[2:0];
      if (!uniq || !seen[c]) begin
        expValid[d][k] = 1'b1;
        expData[d][k] = c;
        expAddr[d][k] = 3'(accepted);
        expDigits[d][accepted*3 +: 3] = c;
        seen[c] = 1'b1;
        accepted++;
        if (accepted == n) doneCyc[d] = k;
      end
      l = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] seedVal, input bit useSeed, input bit glitch);
    logic [7:0] s;
    int maxDone;
    logic [63:0] dig;
    logic v, b, dn;
    logic [2:0] a, dt;
    @(negedge clk);
    use_seed_i = useSeed;
    seed_i = seedVal;
    start_i = 1'b1;
    s = useSeed ? seedVal : entropyModel;
    maxDone = 0;
    for (int d = 0; d < NDUT; d++) begin
      buildModel(d, s);
      if (doneCyc[d] > maxDone) maxDone = doneCyc[d];
    end
    for (int k = 0; k <= maxDone + 1; k++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        fetchDut(d, dig, v, a, dt, b, dn);
        checkOutput($sformatf("s%0h d%0d k%0d valid", s, d, k), 64'(v), 64'(expValid[d][k]));
        if (expValid[d][k]) begin
          checkOutput($sformatf("s%0h d%0d k%0d addr", s, d, k), 64'(a), 64'(expAddr[d][k]));
          checkOutput($sformatf("s%0h d%0d k%0d data", s, d, k), 64'(dt), 64'(expData[d][k]));
        end
        checkOutput($sformatf("s%0h d%0d k%0d busy", s, d, k), 64'(b), 64'(k < doneCyc[d]));
        checkOutput($sformatf("s%0h d%0d k%0d done", s, d, k), 64'(dn), 64'(k >= doneCyc[d]));
      end
      start_i = (glitch && (k + 1 <= 5)) ? 1'($urandom_range(0, 1)) : 1'b0;
      seed_i = 8'($urandom);
      use_seed_i = 1'($urandom_range(0, 1));
    end
    for (int d = 0; d < NDUT; d++) begin
      fetchDut(d, dig, v, a, dt, b, dn);
      checkOutput($sformatf("s%0h d%0d digits", s, d), dig, expDigits[d]);
    end
  endtask

  task automatic checkSeedOneDigits(input string tag);
    checkOutput({tag, " A digits"}, 64'(digitsA), 64'({3'd7, 3'd6, 3'd4, 3'd0, 3'd1}));
    checkOutput({tag, " B digits"}, 64'(digitsB), 64'({3'd1, 3'd3, 3'd7, 3'd6, 3'd4, 3'd0, 3'd1}));
    checkOutput({tag, " C digits"}, 64'(digitsC), 64'({3'd2, 3'd3, 3'd7, 3'd6, 3'd4, 3'd0, 3'd1}));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkIdle("reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkIdle("idle");

    $display("[TB] seed 01 run");
    applyStimulus(8'h01, 1'b1, 1'b0);
    checkSeedOneDigits("seed01");

    $display("[TB] seed 00 run from DONE");
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkSeedOneDigits("seed00");

    $display("[TB] seed 01 with start pulses during GEN");
    applyStimulus(8'h01, 1'b1, 1'b1);
    checkSeedOneDigits("glitch");

    $display("[TB] reset in the middle of a run");
    @(negedge clk);
    start_i = 1'b1;
    use_seed_i = 1'b1;
    seed_i = 8'h01;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 checkIdle("midreset");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h01, 1'b1, 1'b0);
    checkSeedOneDigits("postreset");

    $display("[TB] randomized runs");
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      applyStimulus(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/random_digit_gen.md
# random_digit_gen

Parametrised random-digit generator: on a start request it seeds an internal Galois LFSR and fills a bank of NUM_DIGITS digits of DIGIT_W bits each, one candidate per clock. The seed comes from a free-running entropy counter or from an external seed. An optional unique mode rejects repeated digits. It sits between the game/control FSM (start, done) and the display/compare logic, which reads the packed digit bus or consumes the per-digit write strobe.

## Interface
- NUM_DIGITS, 5: digits generated per run; must be at least 1.
- DIGIT_W, 3: bits per digit (3 gives octal digits).
- LFSR_W, 8: LFSR and entropy-counter width; must be at least DIGIT_W.
- POLY, 8'hB8: Galois feedback mask; must be maximal-length for LFSR_W.
- UNIQUE, 0: 1 rejects a candidate equal to any digit already accepted in the current run.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  run request; sampled on each rising edge.
- use_seed_i  in  1  when start is accepted: 1 seeds from seed_i, 0 seeds from the entropy counter.
- seed_i  in  LFSR_W  external seed.
- digits_o  out  NUM_DIGITS*DIGIT_W  packed digits; digit i is at [i*DIGIT_W +: DIGIT_W].
- wr_valid_o  out  1  one-cycle strobe per accepted digit.
- wr_addr_o  out  IDX_W  index of the accepted digit, with IDX_W = max(1, clog2(NUM_DIGITS)).
- wr_data_o  out  DIGIT_W  value of the accepted digit.
- busy_o  out  1  high while in GEN.
- done_o  out  1  high from run completion until the next accepted start or reset.

## Operation
- States:
  - IDLE: after reset.
  - GEN: generating.
  - DONE: run complete.
- Entropy counter:
  - LFSR_W bits, free-running, increments every clock including during GEN.
  - Wraps at 2^LFSR_W-1 to 0.
- Start acceptance:
  - A start is accepted when start_i=1 in IDLE or DONE.
  - start_i is ignored in GEN.
- On the accepted-start edge:
  - Seed s = use_seed_i ? seed_i : entropy.
  - LFSR is loaded with s; if s==0, the LFSR is loaded with 1 (lockup guard).
  - idx cleared to 0; done_o cleared; busy_o set; state goes to GEN.
  - digits_o keeps the previous run's values until overwritten.
- GEN, each edge:
  - Candidate c = lfsr[DIGIT_W-1:0].
  - Accept c unless UNIQUE=1 and c matches any of digits[0..idx-1].
  - LFSR always advances: next = (lfsr>>1) ^ (lfsr[0] ? POLY : 0). This applies on rejection too.
- On accept:
  - digits[idx] <= c.
  - wr_valid_o=1, wr_addr_o=idx, wr_data_o=c, all for that one cycle.
  - If idx==NUM_DIGITS-1: go to DONE, done_o<=1, busy_o<=0. Otherwise idx++.
- On reject: no write and no strobe.
  - Termination is guaranteed because a maximal-length LFSR visits every low-bit pattern within 2^LFSR_W-1 steps.
- Elaboration error for any of:
  - UNIQUE=1 with NUM_DIGITS > 2^DIGIT_W.
  - LFSR_W < DIGIT_W.
  - NUM_DIGITS < 1.

## Timing
- Reset values:
  - state=IDLE, idx=0, lfsr=1, entropy=0.
  - digits_o=0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, done_o=0.
- All outputs are registered.
- Latency:
  - Start is accepted at edge E0.
  - With UNIQUE=0 or no rejections, digits are written at E1..EN (N=NUM_DIGITS).
  - done_o rises after EN, coincident with the last wr_valid_o.
  - Each rejection adds one cycle.
- A start held high continuously restarts a new run the cycle after DONE is entered. This is intended auto-repeat.
- Reset mid-GEN aborts immediately to reset values; no partial strobe is issued.

## Structure
- Shared package rdg_pkg holds:
  - the state enum (IDLE/GEN/DONE);
  - the default POLY constant for LFSR_W=8;
  - the IDX_W helper function.
- One sub-module, lfsr_galois, parametrised on LFSR_W and POLY, with ports clk, rst, load, load_val, step, q. It contains the zero-seed guard.
- The uniqueness compare is a combinational loop over the digit bank in the top module.

## Test plan
- Reset, no start: all outputs 0; busy_o=0 and done_o=0 indefinitely.
- Defaults, UNIQUE=0, use_seed_i=1, seed_i=8'h01, one start pulse:
  - Strobes at E1..E5 with addr 0..4 and data 1,0,4,6,7.
  - done_o rises with the E5 strobe; digits_o={7,6,4,0,1}.
- NUM_DIGITS=7, seed 8'h01:
  - UNIQUE=0 yields 1,0,4,6,7,3,1, with done after 7 cycles.
  - UNIQUE=1 yields 1,0,4,6,7,3,2: three rejections (1,0,4), done after 10 cycles, no strobe on rejected cycles.
- seed_i=8'h00: behaves identically to seed 8'h01.
- start pulses during GEN: ignored, with output identical to the seed 8'h01 run. A start in DONE: done_o drops next cycle and a new run proceeds.
- rst asserted at E3 of a run: all outputs return to reset values asynchronously. A new start with seed 8'h01 then reproduces 1,0,4,6,7.
